pwm_deadtime: RTL and testbench

- Downstream stage of the PWM generator. Consumes its single-ended PWM output and produces a complementary high-side/low-side gate pair.
- Inserts programmable dead bands on both transitions.
- Swallows PWM pulses shorter than the active dead band.
- Sits between the PWM counter/compare block and the bridge driver pins.

---
 rtl/pwm_deadtime.sv | 132 +++++++++++++
 tb/tb_pwm_deadtime.sv | 224 ++++++++++++++++++++++
 2 files changed

// File: rtl/pwm_deadtime.sv
// pwm_deadtime: splits a single-ended PWM into a complementary high/low gate pair
// with programmable dead bands on both edges. PWM pulses shorter than the active
// band are swallowed and reported on drop.
// Latency: 1 clk input register + 1 clk registered output (2 clks when dt=0).
// Backpressure: none; the block is free-running and follows pwm_in every clock.
//
// Ports:
//   clk, rst_n        clock, synchronous active-low reset
//   en                output enable, 0 forces both gates off
//   pwm_in            PWM from the generator (same clock domain)
//   dt_rise, dt_fall  dead band in clocks before out_h / out_l assert
//   out_h, out_l      registered gate drives, never both high
//   drop              one-cycle strobe when a transition is swallowed in a band
module pwm_deadtime #(
  parameter int DT_WIDTH = 8
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                en,
  input  logic                pwm_in,
  input  logic [DT_WIDTH-1:0] dt_rise,
  input  logic [DT_WIDTH-1:0] dt_fall,
  output logic                out_h,
  output logic                out_l,
  output logic                drop
);

  typedef enum logic [2:0] {
    S_OFF,
    S_LOW,
    S_DT_RISE,
    S_HIGH,
    S_DT_FALL
  } state_t;

  state_t              state_q, state_d;
  logic [DT_WIDTH-1:0] cnt_q, cnt_d;
  logic                pwm_q;
  logic                out_h_q, out_h_d;
  logic                out_l_q, out_l_d;
  logic                drop_q, drop_d;

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    drop_d  = 1'b0;
    if (!en) begin
      state_d = S_OFF;
      cnt_d   = '0;
    end else begin
      case (state_q)
        // OFF and LOW both head for the high side through a full rise band;
        // OFF with the PWM low goes straight to the low side.
        S_OFF, S_LOW: begin
          if (pwm_q) begin
            if (dt_rise == '0) begin
              state_d = S_HIGH;
            end else begin
              state_d = S_DT_RISE;
              cnt_d   = dt_rise - DT_WIDTH'(1);
            end
          end else begin
            state_d = S_LOW;
          end
        end
        S_DT_RISE: begin
          if (!pwm_q) begin
            // Pulse shorter than the band: fall back without extending it.
            state_d = S_LOW;
            cnt_d   = '0;
            drop_d  = 1'b1;
          end else if (cnt_q == '0) begin
            state_d = S_HIGH;
          end else begin
            cnt_d = cnt_q - DT_WIDTH'(1);
          end
        end
        S_HIGH: begin
          if (!pwm_q) begin
            if (dt_fall == '0) begin
              state_d = S_LOW;
            end else begin
              state_d = S_DT_FALL;
              cnt_d   = dt_fall - DT_WIDTH'(1);
            end
          end
        end
        S_DT_FALL: begin
          if (pwm_q) begin
            state_d = S_HIGH;
            cnt_d   = '0;
            drop_d  = 1'b1;
          end else if (cnt_q == '0) begin
            state_d = S_LOW;
          end else begin
            cnt_d = cnt_q - DT_WIDTH'(1);
          end
        end
        default: begin
          state_d = S_OFF;
          cnt_d   = '0;
        end
      endcase
    end
    // Outputs are decoded from the next state so they register on state entry.
    out_h_d = (state_d == S_HIGH);
    out_l_d = (state_d == S_LOW);
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= S_OFF;
      cnt_q   <= '0;
      pwm_q   <= 1'b0;
      out_h_q <= 1'b0;
      out_l_q <= 1'b0;
      drop_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      pwm_q   <= pwm_in;
      out_h_q <= out_h_d;
      out_l_q <= out_l_d;
      drop_q  <= drop_d;
    end
  end

  assign out_h = out_h_q;
  assign out_l = out_l_q;
  assign drop  = drop_q;

endmodule

// File: tb/tb_pwm_deadtime.sv
// tb_pwm_deadtime: scoreboard bench for pwm_deadtime. A timestamp-based model
// predicts the gate outputs for each edge, pushes them to a queue, and the value
// is popped and compared just after the DUT edge.
module tb_pwm_deadtime;

  localparam int DTW = 8;

  logic           clk = 1'b0;
  logic           rst_n;
  logic           en;
  logic           pwm_in;
  logic [DTW-1:0] dt_rise;
  logic [DTW-1:0] dt_fall;
  logic           out_h;
  logic           out_l;
  logic           drop;

  pwm_deadtime #(.DT_WIDTH(DTW)) dut (
    .clk     (clk),
    .rst_n   (rst_n),
    .en      (en),
    .pwm_in  (pwm_in),
    .dt_rise (dt_rise),
    .dt_fall (dt_fall),
    .out_h   (out_h),
    .out_l   (out_l),
    .drop    (drop)
  );

  always #5 clk = ~clk;

  int n_vec = 0;
  int n_err = 0;
  int cyc   = 0;

  logic [2:0] sb_q[$];

  // Model: which side is driven, plus an optional pending switch that
  // completes at an absolute edge index.
  localparam int M_OFF  = 0;
  localparam int M_LOW  = 1;
  localparam int M_HIGH = 2;
  int m_side = M_OFF;
  int m_tgt  = M_OFF;
  int m_dead = 0;
  bit m_pend = 1'b0;
  bit m_pq   = 1'b0;
  bit e_drop = 1'b0;

  int h_cnt = 0, l_cnt = 0, d_cnt = 0;
  bit ph0 = 1'b0, ph1 = 1'b0, dly_on = 1'b0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h want %0h at cycle %0d", tag, got, exp, cyc);
    end
  endtask

  // Predicts the state after the upcoming edge (index cyc) from current inputs.
  task automatic model_step();
    int want;
    int d;
    e_drop = 1'b0;
    if (!rst_n) begin
      m_side = M_OFF;
      m_pend = 1'b0;
      m_pq   = 1'b0;
    end else begin
      if (!en) begin
        m_side = M_OFF;
        m_pend = 1'b0;
      end else if (m_pend) begin
        if (m_pq != (m_tgt == M_HIGH)) begin
          m_pend = 1'b0;
          m_side = (m_tgt == M_HIGH) ? M_LOW : M_HIGH;
          e_drop = 1'b1;
        end else if (cyc == m_dead) begin
          m_pend = 1'b0;
          m_side = m_tgt;
        end
      end else begin
        want = m_pq ? M_HIGH : M_LOW;
        if (want != m_side) begin
          if (m_side == M_OFF && want == M_LOW) begin
            m_side = M_LOW;
          end else begin
            d = (want == M_HIGH) ? int'(dt_rise) : int'(dt_fall);
            if (d == 0) begin
              m_side = want;
            end else begin
              m_pend = 1'b1;
              m_tgt  = want;
              m_dead = cyc + d;
            end
          end
        end
      end
      m_pq = pwm_in;
    end
  endtask

  task automatic tick();
    logic [2:0] e;
    model_step();
    sb_q.push_back({(!m_pend && m_side == M_HIGH), (!m_pend && m_side == M_LOW), e_drop});
    ph1 = ph0;
    ph0 = pwm_in;
    @(posedge clk);
    #1;
    cyc++;
    e = sb_q.pop_front();
    chk("outs", {29'd0, out_h, out_l, drop}, {29'd0, e});
    chk("overlap", {31'd0, out_h & out_l}, 32'd0);
    if (dly_on) chk("dly2", {31'd0, out_h}, {31'd0, ph1});
    h_cnt += int'(out_h);
    l_cnt += int'(out_l);
    d_cnt += int'(drop);
  endtask

  // Counts edges (first edge after the call is 1) until the chosen gate is high.
  task automatic lat(input string tag, input bit want_h, input int exp_k);
    int k;
    bit hit;
    k   = 0;
    hit = 1'b0;
    for (int i = 1; i <= 40 && !hit; i++) begin
      tick();
      if ((want_h ? out_h : out_l) === 1'b1) begin
        k   = i;
        hit = 1'b1;
      end
    end
    chk(tag, k, exp_k);
  endtask

  initial begin
    rst_n   = 1'b0;
    en      = 1'b1;
    pwm_in  = 1'b1;
    dt_rise = '0;
    dt_fall = '0;

    // Reset holds both gates off even with the PWM high.
    repeat (5) tick();
    rst_n  = 1'b1;
    pwm_in = 1'b0;
    tick();
    tick();
    chk("rst_rel_l", {31'd0, out_l}, 32'd1);

    // Asymmetric dead bands.
    dt_rise = 8'd5;
    dt_fall = 8'd3;
    repeat (3) tick();
    pwm_in = 1'b1;
    lat("rise_lat", 1'b1, 7);
    repeat (5) tick();
    pwm_in = 1'b0;
    lat("fall_lat", 1'b0, 5);
    repeat (3) tick();

    // Short pulse inside a long rise band is swallowed.
    dt_rise = 8'd10;
    h_cnt = 0;
    d_cnt = 0;
    pwm_in = 1'b1;
    repeat (4) tick();
    pwm_in = 1'b0;
    repeat (8) tick();
    chk("abort_drop", d_cnt, 1);
    chk("abort_h", h_cnt, 0);

    // Zero dead time: gates follow the PWM two clocks late.
    dt_rise = '0;
    dt_fall = '0;
    repeat (3) tick();
    d_cnt  = 0;
    dly_on = 1'b1;
    repeat (40) begin
      pwm_in = 1'($urandom_range(0, 1));
      tick();
    end
    dly_on = 1'b0;
    chk("dt0_drop", d_cnt, 0);

    // Enable drop and re-assert with the PWM held high.
    dt_rise = 8'd5;
    dt_fall = 8'd3;
    pwm_in  = 1'b1;
    repeat (10) tick();
    en = 1'b0;
    tick();
    chk("en_off", {30'd0, out_h, out_l}, 32'd0);
    tick();
    en = 1'b1;
    lat("en_lat", 1'b1, 6);

    // Generator-driven run: period 256, compare 100, 8-clock bands.
    dt_rise = 8'd8;
    dt_fall = 8'd8;
    pwm_in  = 1'b0;
    repeat (20) tick();
    for (int p = 0; p < 10; p++) begin
      for (int c = 0; c < 256; c++) begin
        if (p == 1 && c == 0) begin
          h_cnt = 0;
          l_cnt = 0;
          d_cnt = 0;
        end
        pwm_in = (c < 100);
        tick();
      end
    end
    chk("gen_h", h_cnt, 9 * 92);
    chk("gen_l", l_cnt, 9 * 148);
    chk("gen_drop", d_cnt, 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
